// File: rtl/ctrl_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_decoder_if
//   Configuration-command channel between the control-packet decoder and the
//   stage config writers. A command is offered with valid and taken on a
//   cycle where valid and ready are both high.
//
//   valid   command available (producer -> consumer)
//   ready   consumer accepts the command (consumer -> producer)
//   vid     5-bit tenant id
//   mod_id  8-bit target module id
//   res_id  8-bit target resource id within the module
//   index   8-bit entry index
//   data    DATA_WIDTH-bit entry payload
//
//   master: the command producer (decoder)   slave: the command consumer
// ----------------------------------------------------------------------------
interface ctrl_cmd_decoder_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  valid;
  logic                  ready;
  logic [4:0]            vid;
  logic [7:0]            mod_id;
  logic [7:0]            res_id;
  logic [7:0]            index;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid, vid, mod_id, res_id, index, data,
    input  ready
  );

  modport slave (
    input  valid, vid, mod_id, res_id, index, data,
    output ready
  );
endinterface

// File: rtl/ctrl_cmd_decoder.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_decoder
//   Parses control packets arriving from the packet filter (no back-pressure)
//   into configuration write commands. Beat 1 carries the VLAN tag (tenant
//   id), beat 2 the module/resource/index, beat 3 the payload; later beats
//   are discarded. Each complete command is buffered in a first-word
//   fall-through FIFO and offered to the config writers. Completed, dropped
//   (FIFO full) and malformed (short) packets are counted.
//
// Ports
//   clk                 clock
//   aresetn             asynchronous active-low reset
//   ctrl_s_axis_tdata   control beat, byte 0 at [7:0]
//   ctrl_s_axis_tkeep   byte enables (ignored)
//   ctrl_s_axis_tuser   sideband (ignored)
//   ctrl_s_axis_tvalid  beat valid, always accepted
//   ctrl_s_axis_tlast   last beat of packet
//   cfg                 command channel (master side), head of the FIFO
//   cmd_done_cnt        commands pushed into the FIFO
//   cmd_drop_cnt        commands lost to a full FIFO
//   cmd_err_cnt         packets shorter than 3 beats
// ----------------------------------------------------------------------------
module ctrl_cmd_decoder #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CMD_FIFO_DEPTH_BITS  = 3
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic                              ctrl_s_axis_tvalid,
  input  logic                              ctrl_s_axis_tlast,
  ctrl_cmd_decoder_if.master                cfg,
  output logic [31:0]                       cmd_done_cnt,
  output logic [31:0]                       cmd_drop_cnt,
  output logic [31:0]                       cmd_err_cnt
);

  localparam int DEPTH = 1 << CMD_FIFO_DEPTH_BITS;
  localparam int CMD_W = 5 + 8 + 8 + 8 + C_S_AXIS_DATA_WIDTH;

  localparam logic [CMD_FIFO_DEPTH_BITS-1:0] PTR_ONE  = CMD_FIFO_DEPTH_BITS'(1'b1);
  localparam logic [CMD_FIFO_DEPTH_BITS:0]   CNT_ONE  = (CMD_FIFO_DEPTH_BITS + 1)'(1'b1);
  localparam logic [CMD_FIFO_DEPTH_BITS:0]   CNT_FULL = (CMD_FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [CMD_FIFO_DEPTH_BITS:0]   CNT_ZERO = (CMD_FIFO_DEPTH_BITS + 1)'(1'b0);

  typedef enum logic [1:0] {
    ST_BEAT1 = 2'd0,
    ST_BEAT2 = 2'd1,
    ST_BEAT3 = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic lat_vid_s;
  logic lat_fld_s;
  logic cmd_req_s;
  logic err_s;

  logic [4:0]  vid_r;
  logic [7:0]  mod_id_r;
  logic [7:0]  res_id_r;
  logic [7:0]  index_r;
  logic [11:0] vlan_s;

  logic [CMD_W-1:0]               mem_r [DEPTH];
  logic [CMD_FIFO_DEPTH_BITS-1:0] wr_ptr_r;
  logic [CMD_FIFO_DEPTH_BITS-1:0] rd_ptr_r;
  logic [CMD_FIFO_DEPTH_BITS:0]   count_r;
  logic [CMD_FIFO_DEPTH_BITS:0]   count_nxt_s;
  logic                           valid_r;
  logic                           full_s;
  logic                           push_s;
  logic                           drop_s;
  logic                           pop_s;
  logic [CMD_W-1:0]               cmd_s;
  logic [CMD_W-1:0]               head_s;

  // Sideband inputs carry nothing this block needs.
  logic unused_s;
  assign unused_s = ^{ctrl_s_axis_tkeep, ctrl_s_axis_tuser};

  // The 12-bit VLAN id sits at [127:116]; the tenant id is its bits [8:4].
  assign vlan_s = ctrl_s_axis_tdata[127:116];

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_BEAT1;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; gap cycles (tvalid=0) hold the state.
  always_comb begin
    state_nxt_s = state_r;
    if (ctrl_s_axis_tvalid) begin
      case (state_r)
        ST_BEAT1: state_nxt_s = ctrl_s_axis_tlast ? ST_BEAT1 : ST_BEAT2;
        ST_BEAT2: state_nxt_s = ctrl_s_axis_tlast ? ST_BEAT1 : ST_BEAT3;
        ST_BEAT3: state_nxt_s = ctrl_s_axis_tlast ? ST_BEAT1 : ST_DRAIN;
        ST_DRAIN: state_nxt_s = ctrl_s_axis_tlast ? ST_BEAT1 : ST_DRAIN;
        default:  state_nxt_s = ST_BEAT1;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: field latch enables, command request and short-packet flag.
  always_comb begin
    lat_vid_s = 1'b0;
    lat_fld_s = 1'b0;
    cmd_req_s = 1'b0;
    err_s     = 1'b0;
    if (ctrl_s_axis_tvalid) begin
      case (state_r)
        ST_BEAT1: begin
          lat_vid_s = 1'b1;
          err_s     = ctrl_s_axis_tlast;
        end
        ST_BEAT2: begin
          lat_fld_s = 1'b1;
          err_s     = ctrl_s_axis_tlast;
        end
        ST_BEAT3: cmd_req_s = 1'b1;
        ST_DRAIN: cmd_req_s = 1'b0;
        default:  cmd_req_s = 1'b0;
      endcase
    end else begin
      cmd_req_s = 1'b0;
    end
  end

  // Header field capture from beats 1 and 2.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vid_r    <= 5'd0;
      mod_id_r <= 8'd0;
      res_id_r <= 8'd0;
      index_r  <= 8'd0;
    end else begin
      if (lat_vid_s) begin
        vid_r <= vlan_s[8:4];
      end
      if (lat_fld_s) begin
        mod_id_r <= ctrl_s_axis_tdata[119:112];
        res_id_r <= ctrl_s_axis_tdata[127:120];
        index_r  <= ctrl_s_axis_tdata[135:128];
      end
    end
  end

  assign cmd_s  = {vid_r, mod_id_r, res_id_r, index_r, ctrl_s_axis_tdata};

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO is
  // dropped even when the head is popped in the same cycle.
  assign full_s = (count_r == CNT_FULL);
  assign push_s = cmd_req_s & ~full_s;
  assign drop_s = cmd_req_s & full_s;
  assign pop_s  = valid_r & cfg.ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and registered non-empty flag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= cmd_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Head entry is always presented; it only changes on a pop.
  assign head_s     = mem_r[rd_ptr_r];
  assign cfg.valid  = valid_r;
  assign cfg.vid    = head_s[CMD_W-1 -: 5];
  assign cfg.mod_id = head_s[CMD_W-6 -: 8];
  assign cfg.res_id = head_s[CMD_W-14 -: 8];
  assign cfg.index  = head_s[CMD_W-22 -: 8];
  assign cfg.data   = head_s[C_S_AXIS_DATA_WIDTH-1:0];

  // Event counters; the FSM guarantees at most one event per cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_done_cnt <= 32'd0;
      cmd_drop_cnt <= 32'd0;
      cmd_err_cnt  <= 32'd0;
    end else begin
      if (push_s) begin
        cmd_done_cnt <= cmd_done_cnt + 32'd1;
      end
      if (drop_s) begin
        cmd_drop_cnt <= cmd_drop_cnt + 32'd1;
      end
      if (err_s) begin
        cmd_err_cnt <= cmd_err_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_cmd_decoder.sv
// ----------------------------------------------------------------------------
// tb_ctrl_cmd_decoder
//   Directed bench for ctrl_cmd_decoder. Inputs change on the falling edge,
//   outputs are checked on the falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ctrl_cmd_decoder;

  localparam logic [255:0] BG1 = {8{32'hDEADBEEF}};
  localparam logic [255:0] BG2 = {8{32'h5A5AC3C3}};

  logic         clk;
  logic         aresetn;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tlast;
  logic [31:0]  done_cnt;
  logic [31:0]  drop_cnt;
  logic [31:0]  err_cnt;

  int tests_run;
  int tests_failed;
  int n_valid;

  ctrl_cmd_decoder_if #(.DATA_WIDTH(256)) cfg_if ();

  ctrl_cmd_decoder #(
    .C_S_AXIS_DATA_WIDTH (256),
    .C_S_AXIS_TUSER_WIDTH(128),
    .CMD_FIFO_DEPTH_BITS (3)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .ctrl_s_axis_tdata (tdata),
    .ctrl_s_axis_tkeep (tkeep),
    .ctrl_s_axis_tuser (tuser),
    .ctrl_s_axis_tvalid(tvalid),
    .ctrl_s_axis_tlast (tlast),
    .cfg               (cfg_if.master),
    .cmd_done_cnt      (done_cnt),
    .cmd_drop_cnt      (drop_cnt),
    .cmd_err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] mk_b1(input logic [4:0] v);
    logic [255:0] d;
    d = BG1;
    d[124:120] = v;
    return d;
  endfunction

  function automatic logic [255:0] mk_b2(input logic [7:0] m, input logic [7:0] r,
                                         input logic [7:0] i);
    logic [255:0] d;
    d = BG2;
    d[119:112] = m;
    d[127:120] = r;
    d[135:128] = i;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [4:0] v, input logic [7:0] m,
                          input logic [7:0] r, input logic [7:0] i, input logic [255:0] d);
    chk({tag, ".valid"}, 256'(cfg_if.valid), 256'd1);
    chk({tag, ".vid"},   256'(cfg_if.vid),    256'(v));
    chk({tag, ".mod"},   256'(cfg_if.mod_id), 256'(m));
    chk({tag, ".res"},   256'(cfg_if.res_id), 256'(r));
    chk({tag, ".idx"},   256'(cfg_if.index),  256'(i));
    chk({tag, ".data"},  cfg_if.data,         d);
  endtask

  task automatic beat(input logic [255:0] d, input logic last);
    @(negedge clk);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = ~tdata;
  endtask

  task automatic send_pkt(input logic [4:0] v, input logic [7:0] m, input logic [7:0] r,
                          input logic [7:0] i, input logic [255:0] d);
    beat(mk_b1(v), 1'b0);
    beat(mk_b2(m, r, i), 1'b0);
    beat(d, 1'b1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    aresetn      = 1'b0;
    tdata        = '0;
    tkeep        = '1;
    tuser        = '0;
    tvalid       = 1'b0;
    tlast        = 1'b0;
    cfg_if.ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid", 256'(cfg_if.valid), 256'd0);
    chk("rst.data",  cfg_if.data,        256'd0);
    chk("rst.done",  256'(done_cnt),     256'd0);
    chk("rst.drop",  256'(drop_cnt),     256'd0);
    chk("rst.err",   256'(err_cnt),      256'd0);
    aresetn = 1'b1;

    // 1: single packet, consumer ready -> exactly one valid cycle
    cfg_if.ready = 1'b1;
    send_pkt(5'h05, 8'h02, 8'h01, 8'h07, {32{8'hA5}});
    idle();
    chk_head("t1", 5'h05, 8'h02, 8'h01, 8'h07, {32{8'hA5}});
    chk("t1.done", 256'(done_cnt), 256'd1);
    @(negedge clk);
    chk("t1.valid_off", 256'(cfg_if.valid), 256'd0);

    // 2: five beats with gaps -> one command from beat 3
    cfg_if.ready = 1'b0;
    beat(mk_b1(5'h1A), 1'b0); idle();
    beat(mk_b2(8'hC1, 8'hC2, 8'hC3), 1'b0); idle();
    beat({16{16'h1234}}, 1'b0); idle();
    beat({16{16'hFFFF}}, 1'b0); idle();
    beat(mk_b1(5'h03), 1'b1); idle();
    chk_head("t2", 5'h1A, 8'hC1, 8'hC2, 8'hC3, {16{16'h1234}});
    chk("t2.done", 256'(done_cnt), 256'd2);
    chk("t2.err",  256'(err_cnt),  256'd0);
    @(negedge clk); cfg_if.ready = 1'b1;
    @(negedge clk); cfg_if.ready = 1'b0;
    chk("t2.one_cmd", 256'(cfg_if.valid), 256'd0);

    // 3: 1-beat and 2-beat short packets, then a good one
    beat(mk_b1(5'h11), 1'b1);
    beat(mk_b1(5'h12), 1'b0);
    beat(mk_b2(8'h99, 8'h98, 8'h97), 1'b1);
    idle();
    chk("t3.err",  256'(err_cnt),      256'd2);
    chk("t3.none", 256'(cfg_if.valid), 256'd0);
    send_pkt(5'h0C, 8'h44, 8'h55, 8'h66, {4{64'h0123456789ABCDEF}});
    idle();
    chk_head("t3", 5'h0C, 8'h44, 8'h55, 8'h66, {4{64'h0123456789ABCDEF}});
    chk("t3.done", 256'(done_cnt), 256'd3);
    @(negedge clk); cfg_if.ready = 1'b1;
    @(negedge clk); cfg_if.ready = 1'b0;
    chk("t3.one_cmd", 256'(cfg_if.valid), 256'd0);

    // 4: nine packets into a stalled FIFO, then drain in order
    for (int k = 0; k < 9; k++) begin
      send_pkt(5'(k + 1), 8'(8'h10 + k), 8'(8'h20 + k), 8'(k), {32{8'(8'h30 + k)}});
    end
    idle();
    chk("t4.done", 256'(done_cnt), 256'd11);
    chk("t4.drop", 256'(drop_cnt), 256'd1);
    cfg_if.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("t4.e%0d", k), 5'(k + 1), 8'(8'h10 + k), 8'(8'h20 + k), 8'(k),
               {32{8'(8'h30 + k)}});
      @(negedge clk);
    end
    chk("t4.empty", 256'(cfg_if.valid), 256'd0);
    cfg_if.ready = 1'b0;

    // 5: FIFO full, push and pop in the same cycle -> push dropped
    for (int k = 0; k < 8; k++) begin
      send_pkt(5'h02, 8'h01, 8'h03, 8'(8'h40 + k), {32{8'(8'h60 + k)}});
    end
    idle();
    chk("t5.done_full", 256'(done_cnt), 256'd19);
    beat(mk_b1(5'h1F), 1'b0);
    beat(mk_b2(8'hEE, 8'hEE, 8'hEE), 1'b0);
    @(negedge clk);
    tdata        = {32{8'hEE}};
    tvalid       = 1'b1;
    tlast        = 1'b1;
    cfg_if.ready = 1'b1;
    @(negedge clk);
    tvalid       = 1'b0;
    tlast        = 1'b0;
    cfg_if.ready = 1'b0;
    chk("t5.drop", 256'(drop_cnt), 256'd2);
    chk("t5.done", 256'(done_cnt), 256'd19);
    chk("t5.head", 256'(cfg_if.index), 256'h41);
    cfg_if.ready = 1'b1;
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      if (cfg_if.valid) n_valid++;
      @(negedge clk);
    end
    cfg_if.ready = 1'b0;
    chk("t5.occupancy", 256'(n_valid), 256'd7);

    // 6: reset during beat 2 clears everything at once
    send_pkt(5'h07, 8'h07, 8'h07, 8'h07, {32{8'h77}});
    idle();
    chk("t6.pre_valid", 256'(cfg_if.valid), 256'd1);
    beat(mk_b1(5'h09), 1'b0);
    beat(mk_b2(8'h0A, 8'h0B, 8'h0C), 1'b0);
    #2 aresetn = 1'b0;
    #1;
    chk("t6.valid", 256'(cfg_if.valid), 256'd0);
    chk("t6.vid",   256'(cfg_if.vid),    256'd0);
    chk("t6.idx",   256'(cfg_if.index),  256'd0);
    chk("t6.data",  cfg_if.data,         256'd0);
    chk("t6.done",  256'(done_cnt),      256'd0);
    chk("t6.drop",  256'(drop_cnt),      256'd0);
    chk("t6.err",   256'(err_cnt),       256'd0);
    tvalid = 1'b0;
    tlast  = 1'b0;
    #1 aresetn = 1'b1;
    send_pkt(5'h15, 8'h81, 8'h82, 8'h83, {8{32'hCAFEF00D}});
    idle();
    chk_head("t6.post", 5'h15, 8'h81, 8'h82, 8'h83, {8{32'hCAFEF00D}});
    chk("t6.post_done", 256'(done_cnt), 256'd1);
    chk("t6.post_err",  256'(err_cnt),  256'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
